// File: rtl/mult_product_accumulator.sv
// Accumulates a frame of unsigned multiplier products and presents total, term count and overflow.
// Define MULT_ACC_SATURATE_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
`timescale 1ns/1ps
module mult_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 5,
    parameter int MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_forced
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_overflow_q, out_overflow_d;
    logic              out_forced_q, out_forced_d;

    logic              accept;
    logic              close;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;
    logic [CNT_W-1:0]  count_inc;

    assign in_ready  = (state_q != DONE) && !rst;
    assign accept    = in_valid && in_ready;
    assign sum_wide  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign ovf_next  = ovf_q | sum_wide[ACC_W];
    assign count_inc = count_q + CNT_W'(1);
    assign close     = accept && (in_last || (count_inc == CNT_W'(MAX_TERMS)));

`ifdef MULT_ACC_SATURATE_EN
    // Once any add has carried out, the frame stays pinned at full scale.
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
        out_forced_d   = out_forced_q;

        if (clear) begin
            // Result fields keep their last value; only out_valid drops.
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = acc_next;
                        count_d = count_inc;
                        ovf_d   = ovf_next;
                        if (close) begin
                            state_d        = DONE;
                            out_valid_d    = 1'b1;
                            out_sum_d      = acc_next;
                            out_count_d    = count_inc;
                            out_overflow_d = ovf_next;
                            out_forced_d   = !in_last;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_d     = IDLE;
                        acc_d       = '0;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
            out_forced_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
            out_forced_q   <= out_forced_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;
    assign out_forced   = out_forced_q;

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream stage of the 4-bit array multiplier.
- Consumes its 8-bit product through a valid/ready handshake.
- Sums a frame of products (terminated by in_last or a term limit) into a wider accumulator.
- Presents the frame total, term count and overflow status on an output valid/ready port. Forms the accumulate half of a MAC / dot-product path.

Parameters:
- PROD_W, 8, width of incoming product (multiplier output width).
- ACC_W, 16, accumulator and out_sum width; must be >= PROD_W.
- CNT_W, 5, width of the term counter and out_count.
- MAX_TERMS, 16, maximum terms per frame; must satisfy 1 <= MAX_TERMS <= 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards the current frame.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat.
- in_product  input  PROD_W  unsigned product from multiplier.
- in_last  input  1  beat is the final term of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  frame total.
- out_count  output  CNT_W  number of terms accepted in the frame.
- out_overflow  output  1  accumulation exceeded ACC_W bits during the frame.
- out_forced  output  1  frame closed by MAX_TERMS, not by in_last.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; acc=0; count=0.
  - out_valid, out_sum, out_count, out_overflow, out_forced all 0.
  - in_ready=0 while rst is high.
- in_ready = (state != DONE) && !rst. It is a combinational function of registered state only and does not depend on in_valid.
- States:
  - IDLE: acc=0, count=0, no beats taken yet.
  - ACCUM: at least one beat taken.
  - DONE: result held.
- Accept occurs when in_valid && in_ready. On accept:
  - acc <= acc + zero_extend(in_product), computed ACC_W+1 wide.
  - The carry-out sets a sticky ovf flag for the frame.
  - count <= count+1.
  - State goes IDLE->ACCUM, or stays ACCUM.
- Frame close: on an accepted beat with in_last=1, or with count+1 == MAX_TERMS.
  - Next state is DONE.
  - out_sum, out_count and out_overflow are registered from the post-add values.
  - out_forced = !in_last.
  - out_valid=1 on the cycle after the closing beat (latency 1).
  - A single-beat frame (in_last on first beat) is legal: out_count=1.
- DONE:
  - out_valid and all out_* fields are held stable until out_valid && out_ready.
  - in_ready=0.
  - On handshake: next cycle out_valid=0, state=IDLE, acc/count/ovf cleared, in_ready=1.
  - Minimum gap between frames is therefore one cycle after the output handshake.
- in_valid low in ACCUM: acc and count hold. Gaps are unlimited.
- Output fields when out_valid=0: they hold the last result and are don't-care to consumers.
- clear=1 (synchronous):
  - Highest priority below rst.
  - Next cycle: state=IDLE, acc=0, count=0, ovf=0, out_valid=0.
  - Any beat presented in the same cycle is consumed and discarded.
  - A held result in DONE is dropped.
- Async rst mid-frame or mid-DONE: immediate return to reset values; partial frame lost.
- Arithmetic: unsigned only; products are never sign-extended.

Optional Feature:
- Macro: MULT_ACC_SATURATE_EN.
- Defined: when an add carries out, acc clamps to all-ones (2^ACC_W-1) and remains clamped for the rest of the frame. out_overflow=1.
- Undefined: acc wraps modulo 2^ACC_W. out_overflow=1 if any add in the frame carried out.
- Handshake, latency and counts are identical in both builds.

Test Plan:
1. Reset and release -> all outputs 0 during reset; in_ready=1 on first cycle after release; out_valid stays 0 with no input.
2. Beats 6, 15, 225 (last on third), out_ready=0 for 3 cycles -> one cycle after third beat:
   - out_valid=1, out_sum=246, out_count=3, out_overflow=0, out_forced=0.
   - Outputs stable and in_ready=0 until out_ready=1; then out_valid=0 and in_ready=1 next cycle.
3. 16 beats of value 1, in_last never set, random in_valid gaps -> out_sum=16, out_count=16, out_forced=1; beat 17 not accepted until result drained.
4. ACC_W=10, five beats of 225, last on fifth:
   - Default build: out_sum=101, out_overflow=1.
   - With MULT_ACC_SATURATE_EN: out_sum=1023, out_overflow=1.
5. Beats 9, 9, then clear with a beat of 50 in the same cycle, then beat 7 with in_last -> out_sum=7, out_count=1; 9, 9 and 50 discarded.
6. Async rst pulse mid-cycle during ACCUM (after 2 beats) and again during DONE -> outputs 0 immediately; the next frame (single beat 200, last) -> out_sum=200, out_count=1.
